// File: rtl/otter_hazard_pkg.sv
// otter_hazard_pkg: shared constants and types for the Otter hazard unit
package otter_hazard_pkg;
  localparam int FSEL_REGFILE = 0;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JALR   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JAL    = 2'd3
  } pc_src_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: busy bits and outstanding count for long-latency writes
// Ports: CLK/RST_N; DE sources/dest and their valids; issue strobe;
// mc_done/mc_done_rd writeback; sb_haz (RAW/WAW on busy reg); mc_full.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int MC_DEPTH = 2,
  localparam int REG_AW = $clog2(NREGS),
  localparam int CW = $clog2(MC_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] de_adr1,
  input  logic [REG_AW-1:0] de_adr2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_regWrite,
  input  logic              issue,
  input  logic              mc_done,
  input  logic [REG_AW-1:0] mc_done_rd,
  output logic              sb_haz,
  output logic              mc_full
);
  logic [NREGS-1:0] busy, busy_n;
  logic [CW-1:0] cnt;
  logic done;
  assign done = mc_done && busy[mc_done_rd];
  assign sb_haz = (busy[de_adr1] && de_rs1_used) || (busy[de_adr2] && de_rs2_used) ||
                  (busy[de_rd] && de_regWrite);
  assign mc_full = cnt == CW'(MC_DEPTH);
  // Set after clear so a same-cycle issue and done to one rd leaves it busy.
  always_comb begin
    busy_n = busy;
    if (done) busy_n[mc_done_rd] = 1'b0;
    if (issue && de_rd != '0) busy_n[de_rd] = 1'b1;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_n;
      cnt  <= cnt + CW'(issue) - CW'(done);
    end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding selects, decode stall and redirect flush
// Ports: CLK/RST_N; DE and EX operand info; fwd_rd/fwd_we per forwarding
// stage (0 nearest); mc_done/mc_done_rd; pc_source. Outputs fsel1/fsel2
// (0 regfile, k stage k-1), stall_de, flush, mc_full; all 0 while RST_N low.
// HAZ_PERF_CNT_EN adds saturating perf_stall, perf_lu, perf_flush counters.
module hazard_scoreboard_unit
  import otter_hazard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int FWD_STAGES = 2,
  parameter int MC_DEPTH = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int REG_AW = $clog2(NREGS),
  localparam int FSEL_W = $clog2(FWD_STAGES + 1)
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [REG_AW-1:0]                   de_adr1,
  input  logic [REG_AW-1:0]                   de_adr2,
  input  logic                                de_rs1_used,
  input  logic                                de_rs2_used,
  input  logic [REG_AW-1:0]                   de_rd,
  input  logic                                de_regWrite,
  input  logic                                de_is_mc,
  input  logic [REG_AW-1:0]                   ex_adr1,
  input  logic [REG_AW-1:0]                   ex_adr2,
  input  logic                                ex_rs1_used,
  input  logic                                ex_rs2_used,
  input  logic [REG_AW-1:0]                   ex_rd,
  input  logic                                ex_is_load,
  input  logic [FWD_STAGES-1:0][REG_AW-1:0]   fwd_rd,
  input  logic [FWD_STAGES-1:0]               fwd_we,
  input  logic                                mc_done,
  input  logic [REG_AW-1:0]                   mc_done_rd,
  input  logic [1:0]                          pc_source,
  output logic [FSEL_W-1:0]                   fsel1,
  output logic [FSEL_W-1:0]                   fsel2,
  output logic                                stall_de,
  output logic                                flush,
  output logic                                mc_full
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_stall,
  output logic [31:0]                         perf_lu,
  output logic [31:0]                         perf_flush
`endif
);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  logic [FCW-1:0] fcnt;
  logic redirect, flush_i, lu, sb_haz, sb_full, stall_i, issue;
  // Scanning from the farthest stage down lets the nearest match win.
  function automatic logic [FSEL_W-1:0] fwd_sel(input logic [REG_AW-1:0] a, input logic used);
    fwd_sel = FSEL_W'(FSEL_REGFILE);
    for (int k = FWD_STAGES; k >= 1; k--)
      if (fwd_we[k-1] && fwd_rd[k-1] == a && used && a != '0) fwd_sel = FSEL_W'(k);
  endfunction
  assign redirect = pc_src_t'(pc_source) != PC_SEQ;
  assign flush_i = redirect || fcnt != '0;
  assign lu = ex_is_load && ex_rd != '0 &&
              ((de_adr1 == ex_rd && de_rs1_used) || (de_adr2 == ex_rd && de_rs2_used));
  assign stall_i = (lu || sb_haz || (de_is_mc && sb_full)) && !flush_i;
  assign issue = de_is_mc && de_regWrite && !stall_i && !flush_i;
  assign fsel1 = RST_N ? fwd_sel(ex_adr1, ex_rs1_used) : '0;
  assign fsel2 = RST_N ? fwd_sel(ex_adr2, ex_rs2_used) : '0;
  assign stall_de = RST_N && stall_i;
  assign flush = RST_N && flush_i;
  assign mc_full = RST_N && sb_full;
  hazard_scoreboard #(.NREGS(NREGS), .MC_DEPTH(MC_DEPTH)) u_sb (
    .CLK(CLK), .RST_N(RST_N),
    .de_adr1(de_adr1), .de_adr2(de_adr2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_regWrite(de_regWrite),
    .issue(issue), .mc_done(mc_done), .mc_done_rd(mc_done_rd),
    .sb_haz(sb_haz), .mc_full(sb_full)
  );
  // A redirect reloads the hold counter even mid-flush.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) fcnt <= '0;
    else fcnt <= redirect ? FCW'(FLUSH_CYCLES - 1) : fcnt != '0 ? fcnt - FCW'(1) : fcnt;
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      perf_stall <= '0;
      perf_lu    <= '0;
      perf_flush <= '0;
    end else begin
      perf_stall <= perf_stall + 32'(stall_i && ~&perf_stall);
      perf_lu    <= perf_lu + 32'(lu && stall_i && ~&perf_lu);
      perf_flush <= perf_flush + 32'(flush_i && ~&perf_flush);
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed and random checks against a queue-based model
module tb_hazard_scoreboard_unit;
  localparam int FC = 2;
  localparam int MCD = 2;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;
  logic [4:0] de_adr1, de_adr2, de_rd, ex_adr1, ex_adr2, ex_rd, mc_done_rd;
  logic de_rs1_used, de_rs2_used, de_regWrite, de_is_mc;
  logic ex_rs1_used, ex_rs2_used, ex_is_load, mc_done;
  logic [1:0][4:0] fwd_rd;
  logic [1:0] fwd_we, pc_source, fsel1, fsel2;
  logic stall_de, flush, mc_full;
  int n_tests = 0, n_fail = 0;
  int q[$];
  int cyc = 0, flush_until = -1;

  hazard_scoreboard_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .de_adr1(de_adr1), .de_adr2(de_adr2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_regWrite(de_regWrite), .de_is_mc(de_is_mc),
    .ex_adr1(ex_adr1), .ex_adr2(ex_adr2),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd), .pc_source(pc_source),
    .fsel1(fsel1), .fsel2(fsel2), .stall_de(stall_de), .flush(flush), .mc_full(mc_full)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    {de_adr1, de_adr2, de_rd, ex_adr1, ex_adr2, ex_rd, mc_done_rd} = '0;
    {de_rs1_used, de_rs2_used, de_regWrite, de_is_mc} = '0;
    {ex_rs1_used, ex_rs2_used, ex_is_load, mc_done} = '0;
    fwd_rd = '0;
    fwd_we = '0;
    pc_source = '0;
  endtask

  function automatic bit m_busy(int r);
    if (r == 0) return 0;
    foreach (q[i]) if (q[i] == r) return 1;
    return 0;
  endfunction

  function automatic int m_fsel(int a, bit used);
    if (!used || a == 0) return 0;
    for (int k = 0; k < 2; k++) if (fwd_we[k] && fwd_rd[k] == a) return k + 1;
    return 0;
  endfunction

  task automatic step(input string tag);
    bit e_flush, lu, sb, st, e_stall, issue, done;
    #1;
    e_flush = pc_source != 0 || cyc <= flush_until;
    lu = ex_is_load && ex_rd != 0 &&
         ((de_adr1 == ex_rd && de_rs1_used) || (de_adr2 == ex_rd && de_rs2_used));
    sb = (m_busy(de_adr1) && de_rs1_used) || (m_busy(de_adr2) && de_rs2_used) ||
         (m_busy(de_rd) && de_regWrite);
    st = de_is_mc && q.size() == MCD;
    e_stall = (lu || sb || st) && !e_flush;
    issue = de_is_mc && de_regWrite && !e_stall && !e_flush;
    done = mc_done && m_busy(mc_done_rd);
    check({tag, ".fsel1"}, fsel1, m_fsel(ex_adr1, ex_rs1_used));
    check({tag, ".fsel2"}, fsel2, m_fsel(ex_adr2, ex_rs2_used));
    check({tag, ".stall"}, stall_de, e_stall);
    check({tag, ".flush"}, flush, e_flush);
    check({tag, ".full"}, mc_full, q.size() == MCD);
    @(posedge CLK);
    if (done)
      for (int i = 0; i < q.size(); i++)
        if (q[i] == mc_done_rd) begin
          q.delete(i);
          break;
        end
    if (issue) q.push_back(de_rd);
    if (pc_source != 0) flush_until = cyc + FC - 1;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    check("rst.fsel1", fsel1, 0);
    check("rst.fsel2", fsel2, 0);
    check("rst.stall", stall_de, 0);
    check("rst.flush", flush, 0);
    check("rst.full", mc_full, 0);
    q.delete();
    flush_until = -1;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic rand_inputs();
    de_adr1 = 5'($urandom_range(7));
    de_adr2 = 5'($urandom_range(7));
    de_rd = 5'($urandom_range(7));
    ex_adr1 = 5'($urandom_range(7));
    ex_adr2 = 5'($urandom_range(7));
    ex_rd = 5'($urandom_range(7));
    {de_rs1_used, de_rs2_used, de_regWrite, ex_rs1_used, ex_rs2_used} = 5'($urandom);
    de_is_mc = $urandom_range(2) == 0;
    ex_is_load = $urandom_range(3) == 0;
    fwd_rd[0] = 5'($urandom_range(7));
    fwd_rd[1] = 5'($urandom_range(7));
    fwd_we = 2'($urandom);
    mc_done = $urandom_range(2) == 0;
    mc_done_rd = (q.size() != 0 && $urandom_range(3) != 0) ?
                 5'(q[$urandom_range(q.size() - 1)]) : 5'($urandom_range(7));
    pc_source = $urandom_range(7) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
  endtask

  initial begin
    idle();
    RST_N = 1'b1;
    #2;
    fwd_rd[0] = 5; fwd_rd[1] = 5; fwd_we = 2'b11; ex_adr1 = 5; ex_rs1_used = 1;
    ex_is_load = 1; ex_rd = 7; de_adr2 = 7; de_rs2_used = 1; pc_source = 1;
    do_reset();
    idle(); fwd_rd[0] = 5; fwd_rd[1] = 5; fwd_we = 2'b11; ex_adr1 = 5; ex_rs1_used = 1;
    #1 check("fwd_near", fsel1, 1); step("fwd_near");
    fwd_we = 2'b10;
    #1 check("fwd_far", fsel1, 2); step("fwd_far");
    ex_adr1 = 0;
    #1 check("fwd_x0", fsel1, 0); step("fwd_x0");
    idle(); ex_is_load = 1; ex_rd = 7; de_adr2 = 7; de_rs2_used = 1;
    #1 check("lu", stall_de, 1); step("lu");
    ex_rd = 0;
    #1 check("lu_x0", stall_de, 0); step("lu_x0");
    idle(); de_is_mc = 1; de_regWrite = 1; de_rd = 9; step("issue9");
    idle(); de_adr1 = 9; de_rs1_used = 1;
    repeat (3) begin
      #1 check("sb_wait", stall_de, 1); step("sb_wait");
    end
    mc_done = 1; mc_done_rd = 9;
    #1 check("sb_done_cyc", stall_de, 1); step("sb_done_cyc");
    mc_done = 0;
    #1 check("sb_release", stall_de, 0); step("sb_release");
    idle(); de_is_mc = 1; de_regWrite = 1; de_rd = 3; step("issue3");
    de_rd = 4; step("issue4");
    de_rd = 5;
    #1 check("full", mc_full, 1); check("full_stall", stall_de, 1); step("full_stall");
    idle(); mc_done = 1; mc_done_rd = 3; step("done3");
    mc_done = 0;
    #1 check("unfull", mc_full, 0); step("unfull");
    mc_done = 1; mc_done_rd = 4; step("done4");
    idle(); ex_is_load = 1; ex_rd = 7; de_adr2 = 7; de_rs2_used = 1; pc_source = 1;
    #1 check("fl0", flush, 1); check("fl0_nostall", stall_de, 0); step("fl0");
    pc_source = 0;
    #1 check("fl1", flush, 1); step("fl1");
    pc_source = 2;
    #1 check("fl2", flush, 1); step("fl2");
    pc_source = 0;
    #1 check("fl3", flush, 1); check("fl3_nostall", stall_de, 0); step("fl3");
    #1 check("fl4", flush, 0); check("fl4_stall", stall_de, 1); step("fl4");
    idle(); de_is_mc = 1; de_regWrite = 1; de_rd = 9; step("issue9b");
    idle(); pc_source = 1; step("redir");
    pc_source = 0; de_adr1 = 9; de_rs1_used = 1;
    fwd_rd[0] = 5; fwd_we = 2'b01; ex_adr1 = 5; ex_rs1_used = 1;
    #1 check("mid_flush", flush, 1); check("mid_nostall", stall_de, 0);
    do_reset();
    idle(); de_adr1 = 9; de_rs1_used = 1;
    #1 check("post_rst_stall", stall_de, 0); check("post_rst_flush", flush, 0);
    step("post_rst");
    repeat (4) begin
      do_reset();
      repeat (150) begin
        rand_inputs();
        step("rnd");
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised pipeline hazard controller for the Otter pipeline. It generates forwarding selects across a configurable number of writeback-capable stages, stalls decode on load-use and scoreboard hazards, and produces multi-cycle front-end flushes on redirects. A per-register scoreboard tracks outstanding writes from the long-latency unit (mul/div), which completes out of order relative to the main pipe. It sits between the DE/EX pipeline registers and the PC/IF control logic.

## Interface
- NREGS, 32: architectural registers; REG_AW = $clog2(NREGS).
- FWD_STAGES, 2: forwarding sources after EX, index 0 nearest (MEM), then WB, …; FSEL_W = $clog2(FWD_STAGES+1).
- MC_DEPTH, 2: maximum outstanding long-latency ops (1..NREGS-1).
- FLUSH_CYCLES, 2: cycles flush is held per redirect (≥1).

- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- de_adr1, de_adr2  in  REG_AW  DE source registers
- de_rs1_used, de_rs2_used  in  1  DE source valid
- de_rd  in  REG_AW  DE destination
- de_regWrite  in  1  DE writes rd
- de_is_mc  in  1  DE instruction goes to long-latency unit
- ex_adr1, ex_adr2  in  REG_AW  EX sources; ex_rs1_used, ex_rs2_used  in  1
- ex_rd  in  REG_AW; ex_is_load  in  1
- fwd_rd  in  [FWD_STAGES][REG_AW]  destination per forwarding stage
- fwd_we  in  [FWD_STAGES]  write enable per forwarding stage
- mc_done  in  1; mc_done_rd  in  REG_AW  long-latency writeback
- pc_source  in  2  EX-resolved PC select; nonzero = redirect
- fsel1, fsel2  out  FSEL_W  0 = regfile, k = fwd stage k-1
- stall_de  out  1  hold PC, IF/DE, insert bubble into EX
- flush  out  1  kill IF/DE contents
- mc_full  out  1  outstanding count == MC_DEPTH

## Operation
- Forwarding: fselN = lowest k with fwd_we[k-1] && fwd_rd[k-1]==ex_adrN && ex_rsN_used && ex_adrN!=0 (nearest stage wins); else 0.
- Load-use: lu = ex_is_load && ex_rd!=0 && ((de_adr1==ex_rd && de_rs1_used) || (de_adr2==ex_rd && de_rs2_used)).
- Scoreboard: busy[NREGS], busy[0] hardwired 0. sb_haz = (busy[de_adr1] && de_rs1_used) || (busy[de_adr2] && de_rs2_used) || (busy[de_rd] && de_regWrite) (WAW).
- Structural: st_haz = de_is_mc && mc_full.
- stall_de = (lu | sb_haz | st_haz) && !flush.
- Issue: issue = de_is_mc && de_regWrite && !stall_de && !flush. On issue: busy[de_rd] ← 1 (unless rd==0), cnt ← cnt+1.
- Complete: mc_done && busy[mc_done_rd] → busy cleared, cnt ← cnt-1. mc_done to a non-busy register is ignored (no counter change).
- Same-cycle issue and done to same rd: busy stays 1, cnt unchanged.
- Flush: flush = (pc_source!=0) | (fcnt!=0). On pc_source!=0, fcnt ← FLUSH_CYCLES-1 (reload even if already counting); else if fcnt!=0, decrement.
- While RST_N low all outputs are 0.

## Timing
- Forwarding, stall_de, flush combinational from same-cycle inputs and current state; zero latency.
- Scoreboard and counters update on rising CLK; a register cleared by mc_done at edge N is usable by DE in cycle N+1 (no same-cycle bypass of mc_done into sb_haz).
- Redirect in cycle N: flush high in cycles N..N+FLUSH_CYCLES-1.
- Reset: busy=0, cnt=0, fcnt=0, perf counters 0; asynchronous assert, synchronous-to-CLK release.

## Configuration
- HAZ_PERF_CNT_EN defined: adds outputs perf_stall, perf_lu, perf_flush (32-bit each), saturating at 2^32-1, incrementing on cycles with stall_de, with lu && stall_de, and with flush respectively.
- Undefined: ports and counters absent; functional behaviour otherwise identical.

## Structure
- Package otter_hazard_pkg: FSEL_REGFILE constant, opcode constants (LOAD, BRANCH, JAL, JALR), pc_source encoding enum.
- Sub-module hazard_scoreboard: busy vector, outstanding counter, issue/done logic, sb_haz and mc_full outputs.

## Test plan
- fwd_rd={5,5}, fwd_we={1,1}, ex_adr1=5, ex_rs1_used=1 -> fsel1=1 (nearest); fwd_we[0]=0 -> fsel1=2; ex_adr1=0 -> fsel1=0.
- ex_is_load=1, ex_rd=7, de_adr2=7, de_rs2_used=1 -> stall_de=1 one cycle; same with ex_rd=0 -> stall_de=0.
- Issue mc to x9, then DE reads x9 -> stall_de=1 until mc_done_rd=9; stall_de=0 the cycle after done edge.
- MC_DEPTH=2: issue x3, x4 -> mc_full=1; third de_is_mc stalls; mc_done x3 -> mc_full=0 next cycle.
- pc_source=2'b01 one cycle, FLUSH_CYCLES=2 -> flush high 2 cycles; second redirect in cycle 2 -> flush held through cycle 3; stall_de=0 throughout flush.
- Assert RST_N=0 mid-operation with busy x9 and fcnt=1 -> all outputs 0 immediately; after release busy clear, flush=0.
